// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART transmitter between N_REQ
//   byte-stream requesters. A grant covers a whole packet and is released on
//   the packet's last byte, on reaching MAX_PKT_LEN bytes, or when the owner
//   keeps valid low for IDLE_TIMEOUT cycles (abort). Every release is followed
//   by GAP_CLKS idle cycles on the shared line before the next arbitration.
//
// Ports
//   i_clk_sys    system clock
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  per-requester byte valid
//   i_req_data   per-requester byte, requester k at [k*DATA_W +: DATA_W]
//   i_req_last   per-requester last-byte-of-packet marker
//   o_req_ready  per-requester byte accepted (only the granted lane)
//   o_tx_data    byte to the serializer
//   o_tx_valid   byte valid to the serializer
//   i_tx_ready   serializer can accept a byte
//   o_grant      one-hot current owner, 0 when none
//   o_busy       high whenever the arbiter is not idle
//   o_abort      one-cycle pulse when a grant is dropped by timeout
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_PKT_LEN  = 16,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int GAP_CLKS     = 4
) (
    input  logic                    i_clk_sys,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    input  logic [N_REQ-1:0]        i_req_last,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [DATA_W-1:0]       o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_busy,
    output logic                    o_abort
);

    localparam int PTR_W = (N_REQ > 1)        ? $clog2(N_REQ)        : 1;
    localparam int CNT_W = (MAX_PKT_LEN > 1)  ? $clog2(MAX_PKT_LEN)  : 1;
    localparam int TO_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CLKS > 0)     ? $clog2(GAP_CLKS + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(IDLE_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   N_EXT    = (PTR_W + 1)'(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e             state_q;
    logic [N_REQ-1:0]   grant_q;
    logic [PTR_W-1:0]   gidx_q;     // index of the current owner
    logic [PTR_W-1:0]   ptr_q;      // round-robin search start
    logic [CNT_W-1:0]   cnt_q;      // bytes accepted in this grant
    logic [TO_W-1:0]    to_q;       // consecutive owner-idle cycles
    logic [GAP_W-1:0]   gap_q;
    logic               busy_q;
    logic               abort_q;

    // Round-robin pick: first valid requester at or above ptr_q, wrapping.
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W:0]     cand;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!pick_found && i_req_valid[cand[PTR_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // One-hot lane mux driven by the registered grant.
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_q[k]) begin
                sel_valid = i_req_valid[k];
                sel_last  = i_req_last[k];
                sel_data  = i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    logic             handshake;
    logic             pkt_done;
    logic             time_out;
    logic [PTR_W-1:0] ptr_next;

    assign handshake = sel_valid & i_tx_ready;
    // A last byte landing on the length cap is a single ordinary release.
    assign pkt_done  = (state_q == S_XFER) & handshake & (sel_last | (cnt_q == CNT_LAST));
    // A valid cycle always resets the idle count, so valid wins over expiry.
    assign time_out  = (state_q == S_XFER) & ~sel_valid & (to_q == TO_LAST);
    assign ptr_next  = (gidx_q == PTR_MAX) ? '0 : gidx_q + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_q <= N_REQ'(1) << pick_idx;
                        gidx_q  <= pick_idx;
                        cnt_q   <= '0;
                        to_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (pkt_done || time_out) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_next;
                        cnt_q   <= '0;
                        to_q    <= '0;
                        gap_q   <= '0;
                        abort_q <= time_out;
                        if (GAP_CLKS == 0) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else begin
                        if (handshake) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        // Back-pressure with valid high is not idleness.
                        to_q <= sel_valid ? '0 : to_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant     = grant_q;
    assign o_busy      = busy_q;
    assign o_abort     = abort_q;
    assign o_tx_valid  = sel_valid;
    assign o_tx_data   = sel_data;
    assign o_req_ready = grant_q & {N_REQ{i_tx_ready}};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. Requester agents hold byte
//   queues; a transaction-level reference model tracks who owns the line,
//   how many bytes went out in the current grant, how long the owner has been
//   idle and when the post-release gap ends, and predicts every output.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N_REQ        = 4;
    localparam int DATA_W       = 8;
    localparam int MAX_PKT_LEN  = 16;
    localparam int IDLE_TIMEOUT = 1024;
    localparam int GAP_CLKS     = 4;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b1;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*DATA_W-1:0] req_data  = '0;
    logic [N_REQ-1:0]        req_last  = '0;
    logic                    tx_ready  = 1'b0;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_valid;
    logic [N_REQ-1:0]        grant;
    logic                    busy;
    logic                    abort;

    always #10 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ        (N_REQ),
        .DATA_W       (DATA_W),
        .MAX_PKT_LEN  (MAX_PKT_LEN),
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .GAP_CLKS     (GAP_CLKS)
    ) dut (
        .i_clk_sys   (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_abort     (abort)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- requester agents ----------------
    logic [DATA_W-1:0] q_data [N_REQ][$];
    bit                q_last [N_REQ][$];
    bit                en     [N_REQ];
    bit                rnd_gate   = 1'b0;
    int                ready_mode = 0;    // 0: always ready, 1: never, 2: random

    typedef struct {
        int                sess;
        int                lane;
        int                edge_n;
        logic [DATA_W-1:0] b;
    } hs_t;
    hs_t hs_log[$];

    int obs_aborts = 0;
    int abort_edge = 0;
    int obs_gap    = 0;

    task automatic push(input int lane, input logic [DATA_W-1:0] b, input bit l);
        q_data[lane].push_back(b);
        q_last[lane].push_back(l);
    endtask

    function automatic logic [DATA_W-1:0] lane_byte(input int k);
        return req_data[k*DATA_W +: DATA_W];
    endfunction

    // ---------------- reference model ----------------
    int m_owner;   // -1 when nobody owns the line
    int m_sent;    // bytes sent in the current grant
    int m_idle;    // consecutive cycles the owner has shown no valid
    int m_ptr;     // requester that gets first look next time
    int m_rel;     // edge index of the most recent release
    int m_n;       // index of the next clock edge
    int m_sess;
    bit m_abort;

    function automatic void model_reset();
        m_owner = -1;
        m_sent  = 0;
        m_idle  = 0;
        m_ptr   = 0;
        m_rel   = -(GAP_CLKS + 1);
        m_n     = 0;
        m_sess  = 0;
        m_abort = 1'b0;
    endfunction

    function automatic void model_release();
        m_ptr   = (m_owner + 1) % N_REQ;
        m_owner = -1;
        m_rel   = m_n;
    endfunction

    function automatic void model_edge();
        bit done;
        int k;
        m_abort = 1'b0;
        if (m_owner >= 0) begin
            if (req_valid[m_owner]) begin
                m_idle = 0;
                if (tx_ready) begin
                    hs_log.push_back('{m_sess, m_owner, m_n, q_data[m_owner][0]});
                    done = q_last[m_owner][0] || (m_sent + 1 == MAX_PKT_LEN);
                    m_sent++;
                    void'(q_data[m_owner].pop_front());
                    void'(q_last[m_owner].pop_front());
                    if (done) model_release();
                end
            end else begin
                m_idle++;
                if (m_idle == IDLE_TIMEOUT) begin
                    m_abort = 1'b1;
                    model_release();
                end
            end
        end else if (m_n >= m_rel + GAP_CLKS + 1 && req_valid != '0) begin
            for (int i = 0; i < N_REQ; i++) begin
                k = (m_ptr + i) % N_REQ;
                if (req_valid[k]) begin
                    m_owner = k;
                    break;
                end
            end
            m_sent = 0;
            m_idle = 0;
            m_sess++;
        end
        m_n++;
    endfunction

    function automatic bit model_busy();
        return (m_owner >= 0) || ((m_n - 1) < m_rel + GAP_CLKS);
    endfunction

    function automatic bit pending();
        bit p;
        p = model_busy();
        for (int k = 0; k < N_REQ; k++) begin
            if (q_data[k].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    // ---------------- per-cycle driving and checking ----------------
    task automatic drive_inputs();
        for (int k = 0; k < N_REQ; k++) begin
            if (rnd_gate) en[k] = ($urandom_range(0, 9) < 8);
            if (en[k] && q_data[k].size() > 0) begin
                req_valid[k]                 = 1'b1;
                req_data[k*DATA_W +: DATA_W] = q_data[k][0];
                req_last[k]                  = q_last[k][0];
            end else begin
                req_valid[k]                 = 1'b0;
                req_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
                req_last[k]                  = 1'($urandom);
            end
        end
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'b0;
            default: tx_ready = ($urandom_range(0, 9) < 7);
        endcase
    endtask

    task automatic check_comb();
        logic              exp_v;
        logic [DATA_W-1:0] exp_d;
        logic [N_REQ-1:0]  exp_r;
        exp_v = 1'b0;
        exp_d = '0;
        exp_r = '0;
        if (m_owner >= 0) begin
            exp_v = req_valid[m_owner];
            exp_d = lane_byte(m_owner);
            if (tx_ready) exp_r = N_REQ'(1) << m_owner;
        end
        check("tx_valid", tx_valid, exp_v);
        check("tx_data", tx_data, exp_d);
        check("req_ready", req_ready, exp_r);
    endtask

    task automatic check_regs();
        logic [N_REQ-1:0] exp_g;
        exp_g = (m_owner >= 0) ? N_REQ'(1) << m_owner : '0;
        check("grant", grant, exp_g);
        check("busy", busy, model_busy());
        check("abort", abort, m_abort);
        if (abort === 1'b1) begin
            obs_aborts++;
            abort_edge = m_n - 1;
        end
        if (grant === '0 && busy === 1'b1) obs_gap++;
    endtask

    task automatic cycle();
        drive_inputs();
        #1;
        check_comb();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic run_until_idle(input int budget);
        int c;
        c = 0;
        while (pending() && c < budget) begin
            cycle();
            c++;
        end
        check("drain", pending(), 0);
    endtask

    task automatic run_until_hs(input int n, input int budget);
        int c;
        c = 0;
        while (hs_log.size() < n && c < budget) begin
            cycle();
            c++;
        end
        check("wait_hs", hs_log.size(), n);
    endtask

    // Reset is applied between clock edges; outputs must clear at once,
    // before the stimulus is withdrawn.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_grant", grant, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_abort", abort, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_req_ready", req_ready, '0);
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            q_data[k].delete();
            q_last[k].delete();
            en[k] = 1'b1;
        end
        hs_log.delete();
        obs_aborts = 0;
        obs_gap    = 0;
        rnd_gate   = 1'b0;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic int count_sess(input int s);
        int c;
        c = 0;
        foreach (hs_log[i]) if (hs_log[i].sess == s) c++;
        return c;
    endfunction

    logic [DATA_W-1:0] s1_exp [3];
    int                s2_exp [4];

    initial begin
        int total;
        int len;

        s1_exp = '{8'hAC, 8'h55, 8'h0F};
        s2_exp = '{1, 3, 1, 3};
        for (int k = 0; k < N_REQ; k++) en[k] = 1'b1;
        model_reset();
        #2;
        do_reset();

        // Single 3-byte packet from requester 0.
        push(0, 8'hAC, 1'b0);
        push(0, 8'h55, 1'b0);
        push(0, 8'h0F, 1'b1);
        cycle();
        check("s1_grant_latency", grant, 4'b0001);
        run_until_idle(200);
        check("s1_hs_count", hs_log.size(), 3);
        for (int i = 0; i < 3 && i < hs_log.size(); i++) check("s1_byte", hs_log[i].b, s1_exp[i]);
        check("s1_gap_cycles", obs_gap, GAP_CLKS);
        check("s1_busy_end", busy, 1'b0);

        // Requesters 1 and 3 contend, twice.
        do_reset();
        push(1, 8'h11, 1'b1);
        push(3, 8'h33, 1'b1);
        run_until_idle(200);
        push(1, 8'h12, 1'b1);
        push(3, 8'h34, 1'b1);
        run_until_idle(200);
        check("s2_hs_count", hs_log.size(), 4);
        for (int i = 0; i < 4 && i < hs_log.size(); i++) check("s2_order", hs_log[i].lane, s2_exp[i]);

        // 20-byte stream: length cap splits it 16 + 4.
        do_reset();
        for (int i = 0; i < 20; i++) push(2, DATA_W'(8'h40 + i), (i == 19));
        run_until_idle(400);
        check("s3_hs_count", hs_log.size(), 20);
        if (hs_log.size() == 20) begin
            check("s3_first_grant", count_sess(hs_log[0].sess), MAX_PKT_LEN);
            check("s3_second_grant", count_sess(hs_log[19].sess), 4);
            check("s3_regrant_lane", hs_log[19].lane, 2);
        end
        check("s3_no_abort", obs_aborts, 0);

        // Owner goes silent after one byte: timeout abort, requester 1 next.
        do_reset();
        push(0, 8'hA1, 1'b0);
        push(1, 8'hB2, 1'b1);
        run_until_idle(3000);
        check("s4_hs_count", hs_log.size(), 2);
        check("s4_abort_count", obs_aborts, 1);
        if (hs_log.size() == 2) begin
            check("s4_abort_delay", abort_edge - hs_log[0].edge_n, IDLE_TIMEOUT);
            check("s4_next_lane", hs_log[1].lane, 1);
        end

        // Valid returns on the very cycle the timeout would expire.
        do_reset();
        push(0, 8'hC1, 1'b0);
        push(0, 8'hC2, 1'b1);
        run_until_hs(1, 50);
        en[0] = 1'b0;
        repeat (IDLE_TIMEOUT - 1) cycle();
        en[0] = 1'b1;
        run_until_idle(200);
        check("s5_no_abort", obs_aborts, 0);
        check("s5_hs_count", hs_log.size(), 2);
        if (hs_log.size() == 2) check("s5_same_grant", hs_log[1].sess, hs_log[0].sess);

        // Long back-pressure with valid held high.
        do_reset();
        ready_mode = 1;
        push(0, 8'h5A, 1'b1);
        repeat (5000) cycle();
        check("s6_no_hs", hs_log.size(), 0);
        check("s6_no_abort", obs_aborts, 0);
        check("s6_grant_held", grant, 4'b0001);
        ready_mode = 0;
        cycle();
        check("s6_first_ready", hs_log.size(), 1);
        run_until_idle(100);

        // Reset in the middle of a packet, then a fresh grant from count 0.
        do_reset();
        for (int i = 0; i < 5; i++) push(0, DATA_W'(8'h90 + i), (i == 4));
        run_until_hs(2, 50);
        do_reset();
        for (int i = 0; i < 17; i++) push(0, DATA_W'(8'hD0 + i), (i == 16));
        run_until_idle(400);
        check("s7_hs_count", hs_log.size(), 17);
        if (hs_log.size() == 17) check("s7_fresh_count", count_sess(hs_log[0].sess), MAX_PKT_LEN);

        // Randomized traffic on all lanes with random gating and back-pressure.
        do_reset();
        total = 0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int p = 0; p < 3; p++) begin
                len = int'($urandom_range(1, 20));
                for (int i = 0; i < len; i++) push(k, DATA_W'($urandom), (i == len - 1));
                total += len;
            end
        end
        rnd_gate   = 1'b1;
        ready_mode = 2;
        run_until_idle(20000);
        rnd_gate = 1'b0;
        for (int k = 0; k < N_REQ; k++) en[k] = 1'b1;
        check("rnd_hs_count", hs_log.size(), total);
        check("rnd_no_abort", obs_aborts, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
